// File: rtl/cpu_types_pkg.sv
// Shared types for the datapath-to-memory responder.
//   word_t          : 32-bit data/address word
//   ramstate_t      : status reported by the RAM model each cycle
//   memresp_state_t : responder FSM states
//   BAD_WORD        : load value returned when a request times out
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DREQ   = 3'd1,
    IREQ   = 3'd2,
    RESP   = 3'd3,
    HALTED = 3'd4
  } memresp_state_t;

  localparam word_t BAD_WORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/dp_mem_responder_wait_timer.sv
// wait_timer: counts RAM wait cycles for the request in flight.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clear   : zero the count (held while the responder is idle)
//   en      : count this cycle (request outstanding, RAM not ready)
//   expired : count has reached TIMEOUT
// The count saturates at TIMEOUT so it can never wrap back to zero.
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/dp_mem_responder.sv
// dp_mem_responder: serializes datapath fetch and load/store requests onto a
// single-port RAM with variable wait states.
//   CLK, RST            : clock and synchronous active-high reset
//   halt                : datapath halt; drains to HALTED, reported on flushed
//   imemREN, imemaddr   : instruction fetch request
//   dmemREN, dmemWEN    : data read / write request
//   dmemaddr, dmemstore : data address and store word
//   ihit, imemload      : fetch complete pulse and fetched word
//   dhit, dmemload      : data complete pulse and load word
//   flushed, err        : halt drained / a request timed out (both sticky)
//   ramREN, ramWEN      : RAM strobes (at most one high)
//   ramaddr, ramstore   : RAM address and store data
//   ramload, ramstate   : RAM read data and status
// RAM-side outputs depend only on registered state, never on datapath inputs.
module dp_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int DMEM_PRIORITY = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        err,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  memresp_state_t state_q, state_d;
  word_t          req_addr_q, req_store_q;
  logic           req_write_q;
  logic           resp_data_q;
  word_t          imemload_q, dmemload_q;
  logic           err_q;

  logic dreq, in_req, access, expired;

  assign dreq   = dmemREN | dmemWEN;
  assign in_req = (state_q == DREQ) || (state_q == IREQ);
  // ERROR and FREE are treated like BUSY: keep the strobe up and retry.
  assign access = (ramstate_t'(ramstate) == ACCESS);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (state_q == IDLE),
    .en      (in_req && !access),
    .expired (expired)
  );

  // NOTE: a default assignment first means every path assigns state_d, so no
  // latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (halt && !dreq) begin
          state_d = HALTED;
        end else if (DMEM_PRIORITY != 0) begin
          if (dreq)         state_d = DREQ;
          else if (imemREN) state_d = IREQ;
        end else begin
          if (imemREN)      state_d = IREQ;
          else if (dreq)    state_d = DREQ;
        end
      end
      // ACCESS is checked alongside expiry so a same-cycle ACCESS still wins.
      DREQ, IREQ: if (access || expired) state_d = RESP;
      RESP:       state_d = IDLE;
      HALTED:     state_d = HALTED;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: every register, including the request latches and load registers,
  // is reset so the outputs read all-zero straight after RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_store_q <= '0;
      req_write_q <= 1'b0;
      resp_data_q <= 1'b0;
      imemload_q  <= '0;
      dmemload_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE) begin
        if (state_d == DREQ) begin
          req_addr_q  <= dmemaddr;
          req_store_q <= dmemstore;
          req_write_q <= dmemWEN;
        end else if (state_d == IREQ) begin
          req_addr_q  <= imemaddr;
          req_store_q <= '0;
          req_write_q <= 1'b0;
        end
      end

      if (in_req && (state_d == RESP)) begin
        resp_data_q <= (state_q == DREQ);
        if (!access) err_q <= 1'b1;
        if (state_q == IREQ) begin
          imemload_q <= access ? ramload : BAD_WORD;
        end else if (!req_write_q) begin
          // Stores leave dmemload holding the last load value.
          dmemload_q <= access ? ramload : BAD_WORD;
        end
      end
    end
  end

  assign ramWEN   = (state_q == DREQ) && req_write_q;
  assign ramREN   = in_req && !ramWEN;
  assign ramaddr  = in_req ? req_addr_q  : '0;
  assign ramstore = in_req ? req_store_q : '0;

  assign ihit     = (state_q == RESP) && !resp_data_q;
  assign dhit     = (state_q == RESP) &&  resp_data_q;
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;
  assign flushed  = (state_q == HALTED);
  assign err      = err_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed bench for dp_mem_responder. Instance u_dut uses default parameters;
// u_dut_to uses TIMEOUT=4 with its own reset and ramstate for the timeout case.
module tb_dp_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        rst_b = 1'b1;
  logic        halt = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic [1:0]  ramstate_b = 2'd0;

  logic        ihit, dhit, flushed, err, ramREN, ramWEN;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  logic        ihit_b, dhit_b, flushed_b, err_b, ramREN_b, ramWEN_b;
  logic [31:0] imemload_b, dmemload_b, ramaddr_b, ramstore_b;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  dp_mem_responder u_dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .flushed(flushed), .err(err),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  dp_mem_responder #(.DMEM_PRIORITY(1), .TIMEOUT(4)) u_dut_to (
    .CLK(CLK), .RST(rst_b), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit_b), .imemload(imemload_b), .dhit(dhit_b), .dmemload(dmemload_b),
    .flushed(flushed_b), .err(err_b),
    .ramREN(ramREN_b), .ramWEN(ramWEN_b), .ramaddr(ramaddr_b), .ramstore(ramstore_b),
    .ramload(ramload), .ramstate(ramstate_b)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Mutual-exclusion properties of both instances, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      total++;
      if ((ihit && dhit) || (ramREN && ramWEN)) begin
        bad++;
        $display("FAIL onehot: ihit=%b dhit=%b ramREN=%b ramWEN=%b, want at most one of each pair high",
                 ihit, dhit, ramREN, ramWEN);
      end
    end
    if (!rst_b) begin
      total++;
      if ((ihit_b && dhit_b) || (ramREN_b && ramWEN_b)) begin
        bad++;
        $display("FAIL onehot_to: ihit=%b dhit=%b ramREN=%b ramWEN=%b, want at most one of each pair high",
                 ihit_b, dhit_b, ramREN_b, ramWEN_b);
      end
    end
  end

  task automatic test_reset();
    RST = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();
    total++;
    if ({ihit, dhit, imemload, dmemload, flushed, err, ramREN, ramWEN, ramaddr, ramstore} !== '0) begin
      bad++;
      $display("FAIL reset: ihit=%b dhit=%b iload=%h dload=%h fl=%b err=%b ren=%b wen=%b addr=%h st=%h, want all 0",
               ihit, dhit, imemload, dmemload, flushed, err, ramREN, ramWEN, ramaddr, ramstore);
    end
    total++;
    if ({ihit_b, dhit_b, flushed_b, err_b, ramREN_b, ramWEN_b} !== 6'b0) begin
      bad++;
      $display("FAIL reset_to: ihit=%b dhit=%b fl=%b err=%b ren=%b wen=%b, want all 0",
               ihit_b, dhit_b, flushed_b, err_b, ramREN_b, ramWEN_b);
    end
    RST = 1'b0;
  endtask

  task automatic test_fetch();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    ramstate = ST_ACCESS;
    ramload  = 32'h2001_0005;
    tick();
    total++;
    if ({ramREN, ramWEN, ramaddr, ihit} !== {1'b1, 1'b0, 32'h0000_0040, 1'b0}) begin
      bad++;
      $display("FAIL fetch_strobe: ren=%b wen=%b addr=%h ihit=%b, want ren=1 wen=0 addr=00000040 ihit=0",
               ramREN, ramWEN, ramaddr, ihit);
    end
    tick();
    total++;
    if ({ihit, dhit, imemload, ramREN} !== {1'b1, 1'b0, 32'h2001_0005, 1'b0}) begin
      bad++;
      $display("FAIL fetch_hit: ihit=%b dhit=%b iload=%h ren=%b, want ihit=1 dhit=0 iload=20010005 ren=0",
               ihit, dhit, imemload, ramREN);
    end
    imemREN = 1'b0;
    tick();
    total++;
    if ({ihit, ramREN} !== 2'b00) begin
      bad++;
      $display("FAIL fetch_done: ihit=%b ren=%b, want 0 0", ihit, ramREN);
    end
  endtask

  task automatic test_priority();
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0044;
    dmemREN  = 1'b1;
    dmemaddr = 32'h0000_0100;
    ramstate = ST_ACCESS;
    ramload  = 32'h1111_2222;
    tick();
    total++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h0000_0100}) begin
      bad++;
      $display("FAIL prio_first: ren=%b addr=%h, want ren=1 addr=00000100", ramREN, ramaddr);
    end
    tick();
    total++;
    if ({dhit, ihit, dmemload} !== {1'b1, 1'b0, 32'h1111_2222}) begin
      bad++;
      $display("FAIL prio_dhit: dhit=%b ihit=%b dload=%h, want dhit=1 ihit=0 dload=11112222",
               dhit, ihit, dmemload);
    end
    dmemREN = 1'b0;
    ramload = 32'h3333_4444;
    tick();
    total++;
    if ({dhit, ihit, ramREN} !== 3'b000) begin
      bad++;
      $display("FAIL prio_idle: dhit=%b ihit=%b ren=%b, want 0 0 0", dhit, ihit, ramREN);
    end
    tick();
    total++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h0000_0044}) begin
      bad++;
      $display("FAIL prio_second: ren=%b addr=%h, want ren=1 addr=00000044", ramREN, ramaddr);
    end
    tick();
    total++;
    if ({ihit, dhit, imemload, dmemload} !== {1'b1, 1'b0, 32'h3333_4444, 32'h1111_2222}) begin
      bad++;
      $display("FAIL prio_ihit: ihit=%b dhit=%b iload=%h dload=%h, want 1 0 33334444 11112222",
               ihit, dhit, imemload, dmemload);
    end
    imemREN = 1'b0;
    tick();
  endtask

  task automatic test_store();
    dmemWEN   = 1'b1;
    dmemaddr  = 32'h0000_0200;
    dmemstore = 32'hDEAD_BEEF;
    ramstate  = ST_BUSY;
    ramload   = 32'h9999_9999;
    tick();
    for (int i = 1; i <= 4; i++) begin
      total++;
      if ({ramWEN, ramREN, ramaddr, ramstore, dhit} !== {1'b1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 1'b0}) begin
        bad++;
        $display("FAIL store_wait%0d: wen=%b ren=%b addr=%h st=%h dhit=%b, want 1 0 00000200 deadbeef 0",
                 i, ramWEN, ramREN, ramaddr, ramstore, dhit);
      end
      ramstate = (i == 4) ? ST_ACCESS : ST_BUSY;
      tick();
    end
    total++;
    if ({dhit, ihit, ramWEN, dmemload} !== {1'b1, 1'b0, 1'b0, 32'h1111_2222}) begin
      bad++;
      $display("FAIL store_hit: dhit=%b ihit=%b wen=%b dload=%h, want 1 0 0 11112222",
               dhit, ihit, ramWEN, dmemload);
    end
    dmemWEN = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    rst_b      = 1'b0;
    imemREN    = 1'b1;
    imemaddr   = 32'h0000_0080;
    ramstate_b = ST_BUSY;
    ramstate   = ST_ACCESS;
    tick();
    for (int i = 1; i <= 5; i++) begin
      total++;
      if ({ramREN_b, ramaddr_b, ihit_b, err_b} !== {1'b1, 32'h0000_0080, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL timeout_wait%0d: ren=%b addr=%h ihit=%b err=%b, want 1 00000080 0 0",
                 i, ramREN_b, ramaddr_b, ihit_b, err_b);
      end
      tick();
    end
    total++;
    if ({ihit_b, dhit_b, imemload_b, err_b, ramREN_b} !== {1'b1, 1'b0, 32'hBAD1_BAD1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL timeout_hit: ihit=%b dhit=%b iload=%h err=%b ren=%b, want 1 0 bad1bad1 1 0",
               ihit_b, dhit_b, imemload_b, err_b, ramREN_b);
    end
    imemREN = 1'b0;
    tick();
    tick();
    total++;
    if ({err_b, ihit_b, ramREN_b} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_sticky: err=%b ihit=%b ren=%b, want err=1 ihit=0 ren=0",
               err_b, ihit_b, ramREN_b);
    end
    tick();
  endtask

  task automatic test_halt();
    dmemREN  = 1'b1;
    dmemaddr = 32'h0000_0300;
    ramstate = ST_BUSY;
    ramload  = 32'h5555_AAAA;
    tick();
    halt = 1'b1;
    tick();
    total++;
    if ({ramREN, ramaddr, dhit, flushed} !== {1'b1, 32'h0000_0300, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL halt_inflight: ren=%b addr=%h dhit=%b fl=%b, want 1 00000300 0 0",
               ramREN, ramaddr, dhit, flushed);
    end
    ramstate = ST_ACCESS;
    tick();
    total++;
    if ({dhit, dmemload, flushed} !== {1'b1, 32'h5555_AAAA, 1'b0}) begin
      bad++;
      $display("FAIL halt_dhit: dhit=%b dload=%h fl=%b, want 1 5555aaaa 0", dhit, dmemload, flushed);
    end
    dmemREN = 1'b0;
    tick();
    tick();
    total++;
    if ({flushed, ramREN, ramWEN} !== 3'b100) begin
      bad++;
      $display("FAIL halt_flushed: fl=%b ren=%b wen=%b, want 1 0 0", flushed, ramREN, ramWEN);
    end
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0090;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({ramREN, ihit, flushed} !== 3'b001) begin
        bad++;
        $display("FAIL halt_ignore%0d: ren=%b ihit=%b fl=%b, want 0 0 1", i, ramREN, ihit, flushed);
      end
    end
    imemREN = 1'b0;
  endtask

  task automatic test_reset_mid();
    RST  = 1'b1;
    halt = 1'b0;
    tick();
    RST = 1'b0;
    total++;
    if (flushed !== 1'b0) begin
      bad++;
      $display("FAIL rst_unhalt: fl=%b, want 0", flushed);
    end
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0048;
    ramstate = ST_BUSY;
    tick();
    tick();
    total++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h0000_0048}) begin
      bad++;
      $display("FAIL rst_inflight: ren=%b addr=%h, want 1 00000048", ramREN, ramaddr);
    end
    RST = 1'b1;
    tick();
    total++;
    if ({ihit, dhit, imemload, dmemload, flushed, err, ramREN, ramWEN, ramaddr, ramstore} !== '0) begin
      bad++;
      $display("FAIL rst_mid: ihit=%b dhit=%b iload=%h dload=%h fl=%b err=%b ren=%b wen=%b addr=%h st=%h, want all 0",
               ihit, dhit, imemload, dmemload, flushed, err, ramREN, ramWEN, ramaddr, ramstore);
    end
    RST      = 1'b0;
    ramstate = ST_ACCESS;
    ramload  = 32'h0000_0077;
    tick();
    total++;
    if ({ramREN, ramaddr, ihit} !== {1'b1, 32'h0000_0048, 1'b0}) begin
      bad++;
      $display("FAIL rst_refetch: ren=%b addr=%h ihit=%b, want 1 00000048 0", ramREN, ramaddr, ihit);
    end
    tick();
    total++;
    if ({ihit, dhit, imemload} !== {1'b1, 1'b0, 32'h0000_0077}) begin
      bad++;
      $display("FAIL rst_refetch_hit: ihit=%b dhit=%b iload=%h, want 1 0 00000077", ihit, dhit, imemload);
    end
    imemREN = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_timeout();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_mem_responder.md
# dp_mem_responder

Responder end of the datapath-to-memory request interface. It accepts instruction-fetch and data load/store requests from the datapath and serializes them onto a single-port RAM with variable wait states. It returns one-cycle `ihit`/`dhit` strobes with load data, and reports `flushed` once a halt has drained. It sits between the datapath and the RAM model, in place of the cache layer.

## Interface
- `DMEM_PRIORITY`, default 1: when 1, data requests win over fetches that arrive in the same cycle.
- `TIMEOUT`, default 255: maximum RAM wait cycles before a request is aborted.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `halt` in 1: datapath halt.
- `imemREN` in 1: fetch request.
- `imemaddr` in 32: fetch address (word aligned).
- `dmemREN` in 1: data read request.
- `dmemWEN` in 1: data write request.
- `dmemaddr` in 32: data address.
- `dmemstore` in 32: store data.
- `ihit` out 1: fetch complete. One-cycle pulse.
- `imemload` out 32: fetched word, valid while `ihit`=1.
- `dhit` out 1: data access complete. One-cycle pulse.
- `dmemload` out 32: load word, valid while `dhit`=1.
- `flushed` out 1: halt drained. Sticky.
- `err` out 1: timeout occurred. Sticky.
- `ramREN`, `ramWEN` out 1: RAM strobes.
- `ramaddr`, `ramstore` out 32: RAM address and store data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: FREE, BUSY, ACCESS, ERROR.

## Operation
- FSM states: IDLE, DREQ, IREQ, RESP, HALTED.
- IDLE, transitions in priority order:
  - `halt`=1 and no data request → HALTED.
  - Otherwise a data request (`dmemREN|dmemWEN`) → DREQ. Latch addr, store data and the type (`dmemWEN` wins if both are set).
  - Otherwise `imemREN` → IREQ. Latch addr.
  - `DMEM_PRIORITY`=0 reverses the data/fetch ordering only.
- DREQ/IREQ:
  - Drive `ramaddr` and `ramstore` from the latched values, plus exactly one of `ramREN`/`ramWEN`.
  - The wait counter increments each cycle `ramstate`≠ACCESS. BUSY, FREE and ERROR all keep waiting (ERROR = retry).
  - `ramstate`=ACCESS → RESP. Capture `ramload` into the load register (reads only); set the hit type.
  - Counter reaches `TIMEOUT` → RESP with load value 32'hBAD1BAD1 and `err` set.
- RESP:
  - Assert exactly one of `ihit`/`dhit` for one cycle; RAM strobes are low.
  - New requests are ignored in this state, because the datapath's request flags clear on the edge that samples the hit.
  - Always → IDLE.
- HALTED: RAM strobes low, `flushed`=1, all requests ignored until `RST`.
- A halt asserted during DREQ/IREQ takes effect only after RESP → IDLE.
- Stores never change `dmemload`; it holds its last load value.
- Address bits [1:0] pass through unmodified.

## Timing
- `RST`=1 at an edge: state IDLE, wait counter 0, latches 0, and all outputs 0 (`ihit`, `dhit`, `imemload`, `dmemload`, `flushed`, `err`, `ramREN`, `ramWEN`, `ramaddr`, `ramstore`).
- Reset mid-access drops the RAM strobes on that same edge; no hit is issued.
- RAM outputs are functions of state and registered latches only; there is no combinational path from datapath inputs.
- Minimum latency: request sampled in IDLE at cycle 0, RAM strobes in cycle 1, ACCESS in cycle 1, hit in cycle 2. Each extra BUSY cycle adds one cycle.
- `ihit` and `dhit` are never high together. At most one RAM strobe is high in any cycle.
- Wait counter width is `$clog2(TIMEOUT+1)`, compared with ==. It clears on entry to DREQ/IREQ and never wraps.
- An ACCESS arriving in the same cycle the counter hits `TIMEOUT` counts as success; ACCESS wins.

## Structure
- `cpu_types_pkg` holds:
  - `ramstate_t` (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
  - `word_t`.
  - New `memresp_state_t` enum.
  - `BAD_WORD` constant (32'hBAD1BAD1).
- One sub-module, `wait_timer`: a counter with `clear`, `en`, parameter `TIMEOUT`, and output `expired`.

## Test plan
- Fetch at 32'h0000_0040, `ramstate`=ACCESS immediately, `ramload`=32'h2001_0005 → `ramREN`=1 in cycle 1, `ihit`=1 with `imemload`=32'h2001_0005 in cycle 2, `dhit`=0.
- Simultaneous `imemREN` and `dmemREN` (dmemaddr 32'h100) with default `DMEM_PRIORITY` → data served first (`dhit`); fetch served after RESP → IDLE (`ihit`). The two hits are never adjacent to their requests out of order.
- Store of 32'hDEAD_BEEF to 32'h200 with 3 BUSY cycles → `ramWEN`=1, `ramstore`=32'hDEADBEEF for 4 cycles. `dhit` comes 5 cycles after sampling; `dmemload` is unchanged.
- `TIMEOUT`=4, `ramstate` stuck BUSY → `ihit` with `imemload`=32'hBAD1BAD1 after 4 wait cycles; `err`=1 and stays 1.
- `halt` raised during DREQ → access completes with `dhit`, then `flushed`=1. A later `imemREN` produces no `ramREN`.
- `RST` pulsed while in IREQ with BUSY → next cycle all outputs 0 and `ramREN`=0. A fresh fetch afterwards completes normally.
